// File: rtl/relu2_layer_controller.sv
// relu2_layer_controller: applies ReLU to every upstream activation and writes the results into the ReLU2 memory
// Ports: clk/reset (sync, active-high); start launches a pass; busy/done report progress;
// pos_count counts positive results; src_addr/src_data read the upstream memory;
// mem_write_* / mem_data_in drive the ReLU2 write port; mem_read_addr/mem_data_out are
// its read port, exposed to the consumer as cons_read_addr/cons_data, qualified by cons_valid.
module relu2_layer_controller #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 16,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 7
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         pos_count,
    output logic [ADDR_W-1:0]        src_addr,
    input  logic signed [DATA_W-1:0] src_data,
    output logic [ADDR_W-1:0]        mem_write_addr,
    output logic signed [DATA_W-1:0] mem_data_in,
    output logic                     mem_write_enable,
    output logic [ADDR_W-1:0]        mem_read_addr,
    input  logic signed [DATA_W-1:0] mem_data_out,
    input  logic [ADDR_W-1:0]        cons_read_addr,
    output logic signed [DATA_W-1:0] cons_data,
    output logic                     cons_valid
);
    localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3;
    logic [1:0]               state;
    logic [ADDR_W-1:0]        idx;
    logic [ADDR_W-1:0]        wr_addr_q;
    logic signed [DATA_W-1:0] wr_data_q;
    logic                     wr_vld_q;
    logic                     go;
    logic                     last;
    assign go   = start && (state == IDLE || state == DONE);
    assign last = idx == ADDR_W'(DEPTH - 1);
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            idx       <= '0;
            wr_vld_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            pos_count <= '0;
        end else begin
            wr_vld_q <= state == RUN;
            if (state == RUN) begin
                wr_data_q <= (src_data > 0) ? src_data : '0;
                wr_addr_q <= idx;
            end
            // the count saturates at DEPTH so a mis-sized pass can never wrap it
            if (go)
                pos_count <= '0;
            else if (wr_vld_q && wr_data_q > 0 && pos_count != CNT_W'(DEPTH))
                pos_count <= pos_count + 1'b1;
            if (go) begin
                state <= RUN;
                idx   <= '0;
            end else if (state == RUN) begin
                if (last)
                    state <= DRAIN;
                else
                    idx <= idx + 1'b1;
            end else if (state == DRAIN) begin
                state <= DONE;
            end
        end
    end
    assign busy             = state == RUN || state == DRAIN;
    assign done             = state == DONE;
    assign src_addr         = (state == RUN) ? idx : '0;
    assign mem_write_enable = wr_vld_q;
    assign mem_write_addr   = wr_addr_q;
    assign mem_data_in      = wr_data_q;
    assign mem_read_addr    = cons_read_addr;
    assign cons_data        = mem_data_out;
    assign cons_valid       = state == DONE;
endmodule

// File: tb/tb_relu2_layer_controller.sv
// tb_relu2_layer_controller: scoreboard bench for relu2_layer_controller
module tb_relu2_layer_controller;
    logic               clk = 0;
    logic               reset = 1;
    logic               start = 1;
    logic               busy, done, mem_write_enable, cons_valid;
    logic [6:0]         pos_count;
    logic [15:0]        src_addr, mem_write_addr, mem_read_addr;
    logic [15:0]        cons_read_addr = 0;
    logic signed [31:0] src_data, mem_data_in, mem_data_out, cons_data;
    logic signed [31:0] src [64];
    logic signed [31:0] rmem [64];

    typedef struct { int addr; longint data; } wr_t;
    wr_t q[$];
    int total = 0, bad = 0;
    int cyc = 0, e0 = 0, wcount = 0, first_w = 0, last_w = 0;

    relu2_layer_controller dut (
        .clk(clk), .reset(reset), .start(start), .busy(busy), .done(done),
        .pos_count(pos_count), .src_addr(src_addr), .src_data(src_data),
        .mem_write_addr(mem_write_addr), .mem_data_in(mem_data_in),
        .mem_write_enable(mem_write_enable), .mem_read_addr(mem_read_addr),
        .mem_data_out(mem_data_out), .cons_read_addr(cons_read_addr),
        .cons_data(cons_data), .cons_valid(cons_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign src_data     = src[src_addr[5:0]];
    assign mem_data_out = rmem[mem_read_addr[5:0]];
    always @(posedge clk) if (mem_write_enable) rmem[mem_write_addr[5:0]] <= mem_data_in;

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: every presented write must match the head of the scoreboard
    always @(negedge clk) begin
        if (mem_write_enable === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                wr_t e;
                e = q.pop_front();
                chk("wr_addr", longint'(mem_write_addr), longint'(e.addr));
                chk("wr_data", longint'(mem_data_in), e.data);
            end
            wcount++;
            if (wcount == 1) first_w = cyc;
            last_w = cyc;
        end
    end

    task automatic issue_start();
        @(negedge clk);
        for (int i = 0; i < 64; i++) q.push_back('{i, longint'(src[i] > 0 ? src[i] : 0)});
        wcount = 0;
        start = 1;
        @(posedge clk);
        #1;
        e0 = cyc;
        start = 0;
    endtask

    task automatic wait_done(input string name, input int exp_pos);
        int n = 0;
        while (!done && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_latency"}, cyc - e0, 65);
        chk({name, "_writes"}, wcount, 64);
        chk({name, "_span"}, last_w - first_w, 63);
        chk({name, "_pos"}, pos_count, exp_pos);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_cvalid"}, cons_valid, 1);
    endtask

    task automatic wait_idx(input int k);
        int n = 0;
        while (!(busy && src_addr == 16'(k)) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("wait_idx", src_addr, k);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) begin
            src[i]  = i - 32;
            rmem[i] = 32'h5a5a5a5a;
        end
        // reset with start held high
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_we", mem_write_enable, 0);
        chk("rst_pos", pos_count, 0);
        chk("rst_src_addr", src_addr, 0);
        chk("rst_cvalid", cons_valid, 0);
        reset = 0;
        start = 0;
        @(posedge clk);
        #1;
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);

        // mixed-sign ramp
        issue_start();
        chk("e0_busy", busy, 1);
        chk("e0_done", done, 0);
        wait_done("ramp", 31);
        cons_read_addr = 63; #1;
        chk("cons_63", cons_data, 31);
        cons_read_addr = 32; #1;
        chk("cons_32", cons_data, 0);
        cons_read_addr = 0; #1;
        chk("cons_0", cons_data, 0);
        chk("cons_valid", cons_valid, 1);

        // restart directly from DONE
        issue_start();
        chk("restart_cvalid", cons_valid, 0);
        chk("restart_done", done, 0);
        chk("restart_pos", pos_count, 0);
        chk("restart_busy", busy, 1);
        wait_done("ramp2", 31);

        // all non-positive
        for (int i = 0; i < 64; i++) src[i] = 32'sh80000000;
        src[5] = 0;
        issue_start();
        wait_done("neg", 0);
        cons_read_addr = 5; #1;
        chk("neg_cons_5", cons_data, 0);
        cons_read_addr = 63; #1;
        chk("neg_cons_63", cons_data, 0);

        // start while busy is ignored
        for (int i = 0; i < 64; i++) src[i] = 3 * i - 100;
        issue_start();
        wait_idx(20);
        start = 1;
        @(posedge clk);
        #1;
        start = 0;
        wait_done("busy_start", 30);
        chk("busy_start_q", q.size(), 0);

        // reset mid-pass
        for (int i = 0; i < 64; i++) src[i] = i - 32;
        issue_start();
        wait_idx(10);
        reset = 1;
        @(posedge clk);
        #1;
        reset = 0;
        chk("midrst_we", mem_write_enable, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_left", q.size(), 54);
        q.delete();
        @(posedge clk);
        #1;
        chk("midrst_we2", mem_write_enable, 0);
        issue_start();
        wait_done("after_rst", 31);
        cons_read_addr = 40; #1;
        chk("after_rst_cons_40", cons_data, 8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
